// File: rtl/heating_zone_if.sv
// Sensor-side and driver-side signals of the multi-zone heating controller,
// bundled so the controller sees one port for its whole zone bus.
interface heating_zone_if #(
    parameter int ZONES  = 4,
    parameter int TEMP_W = 8
);
    logic [TEMP_W-1:0]       setpoint;
    logic [ZONES*TEMP_W-1:0] temp;
    logic [ZONES-1:0]        presence;
    logic [ZONES-1:0]        window;
    logic [ZONES-1:0]        ac_cool;
    logic [ZONES-1:0]        heat;
    logic [ZONES-1:0]        lockout;

    modport master (
        output setpoint, temp, presence, window, ac_cool,
        input  heat, lockout
    );

    modport slave (
        input  setpoint, temp, presence, window, ac_cool,
        output heat, lockout
    );
endinterface

// File: rtl/heating_zone_controller.sv
// Multi-zone heating enable: per-zone hysteresis/dwell/occupancy FSMs with a
// global cap on how many zones may heat at once.
module heating_zone_controller #(
    parameter int ZONES        = 4,
    parameter int TEMP_W       = 8,
    parameter int HYST         = 2,
    parameter int MIN_ON       = 16,
    parameter int MIN_OFF      = 16,
    parameter int VACANCY_HOLD = 64,
    parameter int MAX_ACTIVE   = 2
) (
    input logic           clk,
    input logic           reset_n,
    heating_zone_if.slave zone_bus
);

    localparam int DWELL_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int CNT_W     = $clog2(DWELL_MAX) + 1;
    localparam int VAC_W     = $clog2(VACANCY_HOLD + 1);
    localparam int CMP_W     = TEMP_W + 2;
    localparam int ACT_W     = $clog2(ZONES + 1) + 1;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF - 1);
    localparam logic [VAC_W-1:0] VAC_LOAD = VAC_W'(VACANCY_HOLD);
    localparam logic [ACT_W-1:0] ACT_CAP  = ACT_W'(MAX_ACTIVE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEAT     = 2'd1,
        HOLD_OFF = 2'd2,
        LOCKOUT  = 2'd3
    } zone_state_t;

    zone_state_t      state_q [ZONES];
    zone_state_t      state_d [ZONES];
    logic [CNT_W-1:0] cnt_q   [ZONES];
    logic [CNT_W-1:0] cnt_d   [ZONES];
    logic [VAC_W-1:0] vac_q   [ZONES];
    logic [VAC_W-1:0] vac_d   [ZONES];

    logic [ZONES-1:0] cold;
    logic [ZONES-1:0] warm;
    logic [ZONES-1:0] occupied;
    logic [ZONES-1:0] request;
    logic [ZONES-1:0] grant;
    logic [ZONES-1:0] heat_d;
    logic [ZONES-1:0] lockout_d;
    logic [ZONES-1:0] heat_q;
    logic [ZONES-1:0] lockout_q;
    logic [ACT_W-1:0] active;
    logic [ACT_W-1:0] granted;

    // Widened compares so temp+HYST and setpoint+HYST can never wrap.
    always_comb begin
        cold     = '0;
        warm     = '0;
        occupied = '0;
        request  = '0;
        for (int i = 0; i < ZONES; i++) begin
            cold[i] = (CMP_W'(zone_bus.temp[i*TEMP_W +: TEMP_W]) + CMP_W'(HYST))
                      < CMP_W'(zone_bus.setpoint);
            warm[i] = CMP_W'(zone_bus.temp[i*TEMP_W +: TEMP_W])
                      >= (CMP_W'(zone_bus.setpoint) + CMP_W'(HYST));
            occupied[i] = zone_bus.presence[i] | (vac_q[i] != '0);
            vac_d[i]    = zone_bus.presence[i] ? VAC_LOAD
                        : (vac_q[i] == '0) ? '0 : vac_q[i] - VAC_W'(1);
            request[i]  = (state_q[i] == IDLE) & ~zone_bus.window[i] & cold[i]
                          & occupied[i] & ~zone_bus.ac_cool[i];
        end
    end

    // Only zones already in HEAT count against the cap, so a slot freed this
    // cycle is first grantable on the next one.
    always_comb begin
        active  = '0;
        granted = '0;
        grant   = '0;
        for (int i = 0; i < ZONES; i++) begin
            if (state_q[i] == HEAT) begin
                active = active + ACT_W'(1);
            end
        end
        granted = active;
        for (int i = 0; i < ZONES; i++) begin
            if (request[i] && (granted < ACT_CAP)) begin
                grant[i] = 1'b1;
                granted  = granted + ACT_W'(1);
            end
        end
    end

    always_comb begin
        heat_d    = '0;
        lockout_d = '0;
        for (int i = 0; i < ZONES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (zone_bus.window[i]) begin
                        state_d[i] = LOCKOUT;
                    end else if (grant[i]) begin
                        state_d[i] = HEAT;
                        cnt_d[i]   = '0;
                    end
                end
                HEAT: begin
                    if (zone_bus.window[i]) begin
                        state_d[i] = LOCKOUT;
                    end else if (zone_bus.ac_cool[i]) begin
                        state_d[i] = HOLD_OFF;
                        cnt_d[i]   = OFF_LOAD;
                    end else if (cnt_q[i] == ON_LAST) begin
                        if (warm[i] || !occupied[i]) begin
                            state_d[i] = HOLD_OFF;
                            cnt_d[i]   = OFF_LOAD;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HOLD_OFF: begin
                    if (zone_bus.window[i]) begin
                        state_d[i] = LOCKOUT;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (!zone_bus.window[i]) begin
                        state_d[i] = HOLD_OFF;
                        cnt_d[i]   = OFF_LOAD;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            heat_d[i]    = (state_d[i] == HEAT);
            lockout_d[i] = (state_d[i] == LOCKOUT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ZONES; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                vac_q[i]   <= '0;
            end
            heat_q    <= '0;
            lockout_q <= '0;
        end else begin
            for (int i = 0; i < ZONES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                vac_q[i]   <= vac_d[i];
            end
            heat_q    <= heat_d;
            lockout_q <= lockout_d;
        end
    end

    assign zone_bus.heat    = heat_q;
    assign zone_bus.lockout = lockout_q;

endmodule

// File: doc/heating_zone_controller.md
# heating_zone_controller

Parametrised multi-zone successor to the single-zone heating enable. Each zone runs its own state machine with:
- hysteresis around a shared setpoint;
- minimum on/off dwell times;
- a presence hold-over timer;
- window lockout and heat/cool mutual exclusion.

A global cap limits how many zones heat at once. The block sits between the sensor front-ends (temperature, motion, window, AC status) and the zone valve/burner drivers.

## Interface
- ZONES, 4, number of independent zones
- TEMP_W, 8, temperature/setpoint width, unsigned
- HYST, 2, hysteresis band half-width in temperature LSBs
- MIN_ON, 16, minimum cycles heat stays high once asserted (≥1)
- MIN_OFF, 16, minimum HOLD_OFF dwell after heat drops (≥1)
- VACANCY_HOLD, 64, cycles a zone counts as occupied after presence falls
- MAX_ACTIVE, 2, maximum zones simultaneously in HEAT (1..ZONES)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- setpoint  in  TEMP_W  shared target temperature
- temp  in  ZONES*TEMP_W  zone i temperature at bits [i*TEMP_W +: TEMP_W]
- presence  in  ZONES  motion detected per zone
- window  in  ZONES  window open per zone
- ac_cool  in  ZONES  AC cooling active per zone
- heat  out  ZONES  heating enable per zone, registered
- lockout  out  ZONES  zone held off by open window, registered

## Operation
- Per-zone states: IDLE, HEAT, HOLD_OFF, LOCKOUT. heat[i]=(state==HEAT); lockout[i]=(state==LOCKOUT).
- Comparisons use TEMP_W+2 bit unsigned arithmetic, with no wrap:
  - cold = temp+HYST < setpoint;
  - warm = temp ≥ setpoint+HYST.
- Occupancy, per zone:
  - vac counter loads VACANCY_HOLD when presence=1, otherwise decrements and saturates at 0;
  - occupied = presence | (vac≠0).
- Dwell counter, per zone: width clog2(max(MIN_ON,MIN_OFF))+1.
- IDLE:
  - window=1 → LOCKOUT;
  - otherwise request = cold & occupied & !ac_cool; a granted request → HEAT, with cnt=0.
- HEAT:
  - window=1 → LOCKOUT immediately, ignoring MIN_ON;
  - else ac_cool=1 → HOLD_OFF immediately, with cnt=MIN_OFF-1;
  - else cnt increments, saturating at MIN_ON-1;
  - else (warm | !occupied) and cnt==MIN_ON-1 → HOLD_OFF, with cnt=MIN_OFF-1.
- HOLD_OFF:
  - window=1 → LOCKOUT;
  - else cnt==0 → IDLE, else cnt decrements.
- LOCKOUT: window=0 → HOLD_OFF, with cnt=MIN_OFF-1.
- Arbitration, evaluated each cycle:
  - active = number of zones currently in HEAT;
  - requesting IDLE zones are granted in ascending index while active+grants_so_far < MAX_ACTIVE;
  - ungranted zones stay IDLE and retry every cycle;
  - a slot freed by a zone leaving HEAT becomes usable the following cycle, not the same one.
- Priority within a zone: window > ac_cool > dwell/thermal rules.

## Timing
- Reset (reset_n=0 at a rising edge) forces:
  - all states → IDLE;
  - cnt=0, vac=0;
  - heat=0, lockout=0.
- Reset mid-HEAT drops heat on that edge, with no HOLD_OFF enforced afterwards.
- Latency: inputs sampled at edge k are reflected on heat/lockout after edge k (1 cycle).
- heat stays high for at least MIN_ON cycles, unless window, ac_cool or reset ends it.
- heat stays low for at least MIN_OFF+1 cycles between pulses: MIN_OFF cycles in HOLD_OFF plus ≥1 cycle in IDLE.
- LOCKOUT exit: the first heat is no earlier than MIN_OFF+2 cycles after window falls.
- Invariants:
  - popcount(heat) ≤ MAX_ACTIVE at all times;
  - heat[i] & lockout[i] is never 1.

## Test plan
All tests use ZONES=4, TEMP_W=8, HYST=2, MIN_ON=4, MIN_OFF=3, VACANCY_HOLD=8, MAX_ACTIVE=2, setpoint=20.

1. Hysteresis and MIN_ON. Zone0: temp=17, presence=1 → heat[0]=1 one cycle later. Then temp=22 on the next cycle → heat[0] stays high exactly 4 cycles, then drops. temp=18 or 19 never asserts heat.
2. Window lockout. Zone1 in HEAT, window=1 → next cycle heat[1]=0, lockout[1]=1. window=0 at cycle t → lockout[1]=0 at t+1, and heat[1] is re-asserted no earlier than t+5.
3. Cap and priority. All zones at temp=10, presence=1 from reset → heat=0011. Force zone0 to exit via ac_cool[0]=1 → heat=0010 one cycle later, then heat=0110 the cycle after.
4. Vacancy hold. Zone2 heating, presence falls at cycle t with temp=10 → heat[2] stays 1 through the 8-cycle hold, then drops, and the zone does not restart while presence=0.
5. ac_cool exclusion. Zone3 HEAT entered 1 cycle ago, ac_cool=1 → heat[3]=0 next cycle despite MIN_ON. With ac_cool then cleared, heat[3] stays 0 for ≥4 cycles.
6. Mid-operation reset. Zones 0 and 1 in HEAT, reset_n=0 for 1 cycle → heat=0000, lockout=0000. With cold and presence still asserted, heat=0011 on the first cycle after reset_n returns high.
